// File: rtl/conv_layer_param.sv
// ---------------------------------------------------------------------------
// conv_layer_param
//
// Streaming K x K convolution layer. It accepts IN_CH raster-scan feature
// maps in parallel, one pixel per channel per accepted cycle, and keeps a
// line buffer per channel. For every window whose bottom-right pixel is the
// pixel just accepted, it produces OUT_CH outputs. Each output is the sum
// over all input channels of window pixel x weight, plus a per-output bias.
// The result is then arithmetically shifted, optionally clamped at zero and
// saturated to OUT_BIT bits. Weights and biases are writable at any time.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset; clears all state
//   valid_in    data_in holds one pixel per channel this cycle
//   data_in     channel c at [c*DATA_BIT +: DATA_BIT], signed
//   wt_we       weight write strobe
//   wt_addr     weight index ((oc*IN_CH+ic)*K+ky)*K+kx
//   wt_data     signed weight
//   bias_we     bias write strobe
//   bias_addr   output channel whose bias is written
//   bias_data   signed bias
//   conv_out    channel oc at [oc*OUT_BIT +: OUT_BIT], signed; held when idle
//   valid_out   conv_out carries a new result this cycle
//   frame_done  pulses together with the last output of a frame
// ---------------------------------------------------------------------------
module conv_layer_param #(
    parameter int WIDTH    = 12,
    parameter int HEIGHT   = 12,
    parameter int K        = 5,
    parameter int IN_CH    = 3,
    parameter int OUT_CH   = 3,
    parameter int DATA_BIT = 12,
    parameter int W_BIT    = 8,
    parameter int OUT_BIT  = 14,
    parameter int SHIFT    = 0,
    parameter int RELU     = 0,
    localparam int NW      = OUT_CH * IN_CH * K * K,
    localparam int WA_W    = (NW > 1) ? $clog2(NW) : 1,
    localparam int BA_W    = (OUT_CH > 1) ? $clog2(OUT_CH) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        valid_in,
    input  logic [IN_CH*DATA_BIT-1:0]   data_in,
    input  logic                        wt_we,
    input  logic [WA_W-1:0]             wt_addr,
    input  logic [W_BIT-1:0]            wt_data,
    input  logic                        bias_we,
    input  logic [BA_W-1:0]             bias_addr,
    input  logic [W_BIT-1:0]            bias_data,
    output logic [OUT_CH*OUT_BIT-1:0]   conv_out,
    output logic                        valid_out,
    output logic                        frame_done
);

    localparam int KK     = K * K;
    // Entry 0 is the newest pixel; the window's top-left pixel sits at the
    // far end, (K-1) rows plus (K-1) pixels back.
    localparam int LB_LEN = (K - 1) * WIDTH + K;
    localparam int PROD_W = DATA_BIT + W_BIT;
    localparam int ACC_W  = DATA_BIT + W_BIT + $clog2(IN_CH * KK) + 1;
    localparam int COL_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int ROW_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((2 ** (OUT_BIT - 1)) - 1);
    localparam logic signed [ACC_W-1:0] OUT_MIN = ACC_W'(-(2 ** (OUT_BIT - 1)));

    // Arithmetic shift followed by the optional clamp of negative values.
    function automatic logic signed [ACC_W-1:0] shift_relu(
        input logic signed [ACC_W-1:0] acc
    );
        logic signed [ACC_W-1:0] v;
        v = acc >>> SHIFT;
        if (RELU != 0 && v[ACC_W-1]) begin
            v = '0;
        end
        return v;
    endfunction

    // Clip to the signed OUT_BIT range.
    function automatic logic signed [OUT_BIT-1:0] saturate(
        input logic signed [ACC_W-1:0] v
    );
        logic signed [OUT_BIT-1:0] r;
        if (v > OUT_MAX) begin
            r = OUT_MAX[OUT_BIT-1:0];
        end else if (v < OUT_MIN) begin
            r = OUT_MIN[OUT_BIT-1:0];
        end else begin
            r = v[OUT_BIT-1:0];
        end
        return r;
    endfunction

    logic signed [DATA_BIT-1:0] lb_q   [IN_CH][LB_LEN];
    logic signed [W_BIT-1:0]    wt_q   [NW];
    logic signed [W_BIT-1:0]    bias_q [OUT_CH];

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             win_d, last_d;

    logic vld_p0_q, last_p0_q;
    logic vld_p1_q, last_p1_q;
    logic vld_p2_q, last_p2_q;

    logic signed [PROD_W-1:0] prod_p1_q [OUT_CH][IN_CH][KK];
    logic signed [ACC_W-1:0]  sum_d     [OUT_CH];
    logic signed [ACC_W-1:0]  sum_p2_q  [OUT_CH];

    // Raster position of the pixel being offered. A window is complete
    // when this pixel is at least K-1 columns and rows into the map.
    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        win_d  = valid_in && (32'(col_q) >= K - 1) && (32'(row_q) >= K - 1);
        last_d = valid_in && (32'(col_q) == WIDTH - 1) && (32'(row_q) == HEIGHT - 1);
        if (valid_in) begin
            if (32'(col_q) == WIDTH - 1) begin
                col_d = '0;
                if (32'(row_q) == HEIGHT - 1) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // Stage 0: line buffers, counters and the window flag of the new pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q     <= '0;
            row_q     <= '0;
            vld_p0_q  <= 1'b0;
            last_p0_q <= 1'b0;
            for (int c = 0; c < IN_CH; c++) begin
                for (int i = 0; i < LB_LEN; i++) begin
                    lb_q[c][i] <= '0;
                end
            end
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            vld_p0_q  <= win_d;
            last_p0_q <= last_d;
            if (valid_in) begin
                for (int c = 0; c < IN_CH; c++) begin
                    lb_q[c][0] <= data_in[c*DATA_BIT +: DATA_BIT];
                    for (int i = 1; i < LB_LEN; i++) begin
                        lb_q[c][i] <= lb_q[c][i-1];
                    end
                end
            end
        end
    end

    // Coefficient storage. Comparing against every legal index means
    // out-of-range addresses simply match nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NW; i++) begin
                wt_q[i] <= '0;
            end
            for (int i = 0; i < OUT_CH; i++) begin
                bias_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NW; i++) begin
                if (wt_we && wt_addr == WA_W'(i)) begin
                    wt_q[i] <= wt_data;
                end
            end
            for (int i = 0; i < OUT_CH; i++) begin
                if (bias_we && bias_addr == BA_W'(i)) begin
                    bias_q[i] <= bias_data;
                end
            end
        end
    end

    // Stage 1: every window pixel times its weight, for every output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q  <= 1'b0;
            last_p1_q <= 1'b0;
            for (int oc = 0; oc < OUT_CH; oc++) begin
                for (int ic = 0; ic < IN_CH; ic++) begin
                    for (int j = 0; j < KK; j++) begin
                        prod_p1_q[oc][ic][j] <= '0;
                    end
                end
            end
        end else begin
            vld_p1_q  <= vld_p0_q;
            last_p1_q <= last_p0_q;
            for (int oc = 0; oc < OUT_CH; oc++) begin
                for (int ic = 0; ic < IN_CH; ic++) begin
                    for (int ky = 0; ky < K; ky++) begin
                        for (int kx = 0; kx < K; kx++) begin
                            prod_p1_q[oc][ic][ky*K+kx] <=
                                PROD_W'(lb_q[ic][(K-1-ky)*WIDTH + (K-1-kx)]) *
                                PROD_W'(wt_q[((oc*IN_CH + ic)*K + ky)*K + kx]);
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        for (int oc = 0; oc < OUT_CH; oc++) begin
            sum_d[oc] = ACC_W'(bias_q[oc]);
            for (int ic = 0; ic < IN_CH; ic++) begin
                for (int j = 0; j < KK; j++) begin
                    sum_d[oc] = sum_d[oc] + ACC_W'(prod_p1_q[oc][ic][j]);
                end
            end
        end
    end

    // Stage 2: full-precision sum plus bias.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2_q  <= 1'b0;
            last_p2_q <= 1'b0;
            for (int oc = 0; oc < OUT_CH; oc++) begin
                sum_p2_q[oc] <= '0;
            end
        end else begin
            vld_p2_q  <= vld_p1_q;
            last_p2_q <= last_p1_q;
            for (int oc = 0; oc < OUT_CH; oc++) begin
                sum_p2_q[oc] <= sum_d[oc];
            end
        end
    end

    // Stage 3: shift, clamp, saturate; conv_out only moves on a valid result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv_out   <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid_out  <= vld_p2_q;
            frame_done <= vld_p2_q && last_p2_q;
            if (vld_p2_q) begin
                for (int oc = 0; oc < OUT_CH; oc++) begin
                    conv_out[oc*OUT_BIT +: OUT_BIT] <= saturate(shift_relu(sum_p2_q[oc]));
                end
            end
        end
    end

endmodule

// File: doc/conv_layer_param.md
Name: conv_layer_param

Overview:
Parametrised streaming convolution layer, the successor to the fixed 3-channel conv2 stage. It takes IN_CH raster-scan feature maps in parallel and builds K×K windows with per-channel line buffers. It computes OUT_CH output maps, each the sum over all input channels of the window-weight products, plus bias. Weights and biases are run-time loadable; output goes through shift, optional ReLU and saturation. It sits between a max-pool stage and the next pool or FC stage.

Parameters:
WIDTH, 12, input map width in pixels (≥K)
HEIGHT, 12, input map height in pixels (≥K)
K, 5, square kernel size (≥2), stride 1, no padding
IN_CH, 3, input channels
OUT_CH, 3, output channels
DATA_BIT, 12, signed input pixel width
W_BIT, 8, signed weight/bias width
OUT_BIT, 14, signed output width
SHIFT, 0, arithmetic right shift applied before saturation
RELU, 0, 1 = clamp negative results to 0

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
valid_in  in  1  data_in carries one pixel per channel this cycle
data_in  in  IN_CH*DATA_BIT  channel c at bits [c*DATA_BIT +: DATA_BIT], signed
wt_we  in  1  weight write strobe
wt_addr  in  clog2(OUT_CH*IN_CH*K*K)  weight index = ((oc*IN_CH+ic)*K+ky)*K+kx
wt_data  in  W_BIT  signed weight
bias_we  in  1  bias write strobe
bias_addr  in  clog2(OUT_CH) (min 1)  output channel index
bias_data  in  W_BIT  signed bias
conv_out  out  OUT_CH*OUT_BIT  channel oc at [oc*OUT_BIT +: OUT_BIT], signed
valid_out  out  1  conv_out valid this cycle
frame_done  out  1  one-cycle pulse with the last output of a frame

Behaviour:
- Reset (async, rst_n=0): line buffers, weights, biases, col/row counters, pipeline registers = 0; conv_out=0, valid_out=0, frame_done=0.
- Line buffer per channel: shift register of (K-1)*WIDTH+K entries, shifts only when valid_in=1. No backpressure; valid_in=0 freezes buffers and counters.
- Counters col (0..WIDTH-1) and row (0..HEIGHT-1) advance on each accepted pixel. col wraps to 0 and row increments. At col=WIDTH-1,row=HEIGHT-1 both wrap to 0, so back-to-back frames need no gap.
- Window valid when the accepted pixel has col≥K-1 and row≥K-1 (pixel = window bottom-right). Outputs per frame = (WIDTH-K+1)*(HEIGHT-K+1).
- Pipeline, 3 stages, advancing every cycle: S1 registers all products (window pixel × weight, signed); S2 registers the adder-tree sum plus sign-extended bias; S3 applies >>>SHIFT, optional ReLU, and saturation to [-2^(OUT_BIT-1), 2^(OUT_BIT-1)-1], and registers conv_out.
- Latency: a window-valid pixel accepted at edge t gives valid_out=1 after edge t+3. The valid flag travels with the data. Non-window pixels and idle cycles give valid_out=0.
- conv_out holds its last value while valid_out=0.
- Accumulator width = DATA_BIT+W_BIT+clog2(IN_CH*K*K)+1, so no internal overflow.
- frame_done=1 in the same cycle as valid_out for the window at col=WIDTH-1,row=HEIGHT-1.
- Weight/bias writes are accepted any cycle. They affect S1/S2 from the next edge on. Out-of-range addresses are ignored. wt_we and bias_we may be asserted together.
- A write in the same cycle as a window uses the old value for that window.
- Reset mid-frame discards in-flight results. The next frame restarts at col=row=0, and weights must be reloaded.

Test Plan:
Bench config WIDTH=HEIGHT=6, K=3, IN_CH=OUT_CH=2, DATA_BIT=12, OUT_BIT=14 unless stated.
1. All weights 1, biases 0, every pixel 1, valid_in held high for 36 cycles -> 16 valid_out pulses, each conv_out channel = 18. First pulse 3 cycles after the 15th pixel; frame_done with the 16th.
2. Only weight (oc0,ic0,ky1,kx1)=1, ch0 pixel = row*6+col -> oc0 outputs 7,8,9,10,13,...,28; oc1 = 0.
3. Weights 1, bias oc1 = -5, SHIFT=1, pixels 1 -> oc0 = 9, oc1 = 6.
4. OUT_BIT=12: pixels 2047 with weights 127 -> 2047 (saturated); pixels 2047 with weights -128 -> -2048 if RELU=0, 0 if RELU=1.
5. Run test 1 with valid_in alternating 1/0 and random gaps -> same 16 values. Each pulse is exactly 3 cycles after its bottom-right pixel; two consecutive frames yield 32 pulses and 2 frame_done.
6. Drop rst_n after 20 pixels -> outputs and flags 0 immediately. After reload, a fresh frame gives its first output after its 15th pixel, with no stale data.
